// File: rtl/drive_ramp_sequencer.sv
// Left/right motor speed sequencer: one speed code per step tick, ramp-to-stop plus dead
// time around direction reversals, and a command watchdog that ramps both channels to stop.
module drive_ramp_sequencer #(
   parameter int unsigned STEP_CYCLES = 5_000_000,
   parameter int unsigned DEAD_CYCLES = 10_000_000,
   parameter int unsigned WDOG_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_dir_l,
   input  logic [1:0] cmd_spd_l,
   input  logic       cmd_dir_r,
   input  logic [1:0] cmd_spd_r,
   output logic [1:0] speed_l,
   output logic [1:0] speed_r,
   output logic       dir_l,
   output logic       dir_r,
   output logic       busy,
   output logic       wdog_trip
);

   localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [PW-1:0] STEP_LAST = PW'(STEP_CYCLES - 1);
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
   localparam logic [WW-1:0] WDOG_PRE  = WW'(WDOG_CYCLES - 2);

   typedef enum logic [1:0] {IDLE, RAMP, DEAD} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   presc, presc_nx;
   logic [DW-1:0]   dead_cnt, dead_nx;
   logic [WW-1:0]   wdog_cnt, wdog_nx;
   logic [1:0]      tgt_spd_l, tgt_spd_r, tgt_spd_l_nx, tgt_spd_r_nx;
   logic            tgt_dir_l, tgt_dir_r, tgt_dir_l_nx, tgt_dir_r_nx;
   logic [1:0]      speed_l_nx, speed_r_nx;
   logic            dir_l_nx, dir_r_nx, ready_nx, busy_nx, trip_nx;
   logic            accept, mm_l, mm_r, tick, wdog_hit, expire;
   logic [1:0]      eff_l, eff_r;

   function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] tgt);
      if (cur < tgt)
         return cur + 2'd1;
      else if (cur > tgt)
         return cur - 2'd1;
      else
         return cur;
   endfunction

   assign accept   = cmd_valid & cmd_ready;
   assign mm_l     = (tgt_dir_l != dir_l);
   assign mm_r     = (tgt_dir_r != dir_r);
   assign eff_l    = mm_l ? 2'd0 : tgt_spd_l;
   assign eff_r    = mm_r ? 2'd0 : tgt_spd_r;
   assign tick     = (presc == STEP_LAST);
   // Expiry fires on the cycle the counter would reach its last value; an accept overrides it.
   assign wdog_hit = (WDOG_CYCLES == 0) ? 1'b0 :
                     (WDOG_CYCLES == 1) ? ~wdog_trip : (wdog_cnt == WDOG_PRE);
   assign expire   = wdog_hit & ~accept;

   always_comb begin
      state_nx     = state;
      presc_nx     = presc;
      dead_nx      = dead_cnt;
      wdog_nx      = wdog_cnt;
      tgt_spd_l_nx = tgt_spd_l;
      tgt_spd_r_nx = tgt_spd_r;
      tgt_dir_l_nx = tgt_dir_l;
      tgt_dir_r_nx = tgt_dir_r;
      speed_l_nx   = speed_l;
      speed_r_nx   = speed_r;
      dir_l_nx     = dir_l;
      dir_r_nx     = dir_r;
      trip_nx      = wdog_trip;

      if (accept)
         wdog_nx = '0;
      else if (WDOG_CYCLES != 0 && wdog_cnt != WDOG_LAST)
         wdog_nx = wdog_cnt + 1'b1;

      if (accept) begin
         trip_nx      = 1'b0;
         tgt_spd_l_nx = cmd_spd_l;
         tgt_spd_r_nx = cmd_spd_r;
         tgt_dir_l_nx = cmd_dir_l;
         tgt_dir_r_nx = cmd_dir_r;
      end else if (expire) begin
         trip_nx      = 1'b1;
         tgt_spd_l_nx = 2'd0;
         tgt_spd_r_nx = 2'd0;
         tgt_dir_l_nx = dir_l;
         tgt_dir_r_nx = dir_r;
      end

      case (state)
         IDLE: begin
            presc_nx = '0;
            if (accept && ({cmd_dir_l, cmd_spd_l, cmd_dir_r, cmd_spd_r} !=
                           {dir_l, speed_l, dir_r, speed_r}))
               state_nx = RAMP;
            else if (expire && (speed_l != 2'd0 || speed_r != 2'd0))
               state_nx = RAMP;
         end
         RAMP: begin
            presc_nx = tick ? '0 : presc + 1'b1;
            if (tick) begin
               speed_l_nx = step_toward(speed_l, eff_l);
               speed_r_nx = step_toward(speed_r, eff_r);
            end
            // Targets changing this cycle defer the exit decision to the next cycle.
            if (!accept && !expire) begin
               if ((mm_l || mm_r) && (!mm_l || speed_l == 2'd0) && (!mm_r || speed_r == 2'd0)) begin
                  state_nx = DEAD;
                  presc_nx = '0;
                  dead_nx  = '0;
               end else if (!mm_l && !mm_r && speed_l == tgt_spd_l && speed_r == tgt_spd_r) begin
                  state_nx = IDLE;
               end
            end
         end
         DEAD: begin
            dead_nx = dead_cnt + 1'b1;
            if (dead_cnt == DEAD_LAST) begin
               dir_l_nx = tgt_dir_l_nx;
               dir_r_nx = tgt_dir_r_nx;
               state_nx = RAMP;
               presc_nx = '0;
               dead_nx  = '0;
            end
         end
         default: state_nx = IDLE;
      endcase

      ready_nx = (state_nx != DEAD);
      busy_nx  = (state_nx != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         presc     <= '0;
         dead_cnt  <= '0;
         wdog_cnt  <= '0;
         tgt_spd_l <= 2'd0;
         tgt_spd_r <= 2'd0;
         tgt_dir_l <= 1'b0;
         tgt_dir_r <= 1'b0;
         speed_l   <= 2'd0;
         speed_r   <= 2'd0;
         dir_l     <= 1'b0;
         dir_r     <= 1'b0;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         wdog_trip <= 1'b0;
      end else begin
         state     <= state_nx;
         presc     <= presc_nx;
         dead_cnt  <= dead_nx;
         wdog_cnt  <= wdog_nx;
         tgt_spd_l <= tgt_spd_l_nx;
         tgt_spd_r <= tgt_spd_r_nx;
         tgt_dir_l <= tgt_dir_l_nx;
         tgt_dir_r <= tgt_dir_r_nx;
         speed_l   <= speed_l_nx;
         speed_r   <= speed_r_nx;
         dir_l     <= dir_l_nx;
         dir_r     <= dir_r_nx;
         cmd_ready <= ready_nx;
         busy      <= busy_nx;
         wdog_trip <= trip_nx;
      end
   end

endmodule

// File: tb/tb_drive_ramp_sequencer.sv
// Directed bench for drive_ramp_sequencer: ramp, reversal, retarget, watchdog and async reset,
// with hand-computed cycle offsets from each accept edge.
module tb_drive_ramp_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_dir_l, cmd_dir_r;
   logic [1:0] cmd_spd_l, cmd_spd_r;
   logic [1:0] speed_l, speed_r;
   logic       dir_l, dir_r, busy, wdog_trip;

   int n_tests = 0;
   int n_fail  = 0;
   logic bad_dir  = 1'b0;
   logic bad_step = 1'b0;
   logic [1:0] p_sl = 2'd0, p_sr = 2'd0;
   logic p_dl = 1'b0, p_dr = 1'b0;

   drive_ramp_sequencer #(
      .STEP_CYCLES(4),
      .DEAD_CYCLES(6),
      .WDOG_CYCLES(100)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir_l(cmd_dir_l), .cmd_spd_l(cmd_spd_l),
      .cmd_dir_r(cmd_dir_r), .cmd_spd_r(cmd_spd_r),
      .speed_l(speed_l), .speed_r(speed_r),
      .dir_l(dir_l), .dir_r(dir_r),
      .busy(busy), .wdog_trip(wdog_trip)
   );

   always #5 clk = ~clk;

   // Invariants: dir changes only with speed at 00 on both sides of the change; steps of at most one code.
   always @(negedge clk) begin
      if (rst) begin
         if ((dir_l != p_dl && (p_sl != 2'd0 || speed_l != 2'd0)) ||
             (dir_r != p_dr && (p_sr != 2'd0 || speed_r != 2'd0)))
            bad_dir = 1'b1;
         if ((int'(speed_l) - int'(p_sl)) > 1 || (int'(speed_l) - int'(p_sl)) < -1 ||
             (int'(speed_r) - int'(p_sr)) > 1 || (int'(speed_r) - int'(p_sr)) < -1)
            bad_step = 1'b1;
      end
      p_sl = speed_l; p_sr = speed_r; p_dl = dir_l; p_dr = dir_r;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic dl, input logic [1:0] sl, input logic dr, input logic [1:0] sr);
      check_val("ready_before_send", cmd_ready, 1);
      cmd_dir_l = dl; cmd_spd_l = sl; cmd_dir_r = dr; cmd_spd_r = sr;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0;
      cmd_dir_l = 1'b0; cmd_spd_l = 2'd0; cmd_dir_r = 1'b0; cmd_spd_r = 2'd0;
      cyc(3);
      check_val("rst_speed_l", speed_l, 0);
      check_val("rst_speed_r", speed_r, 0);
      check_val("rst_dirs", {dir_l, dir_r}, 0);
      check_val("rst_ready", cmd_ready, 0);
      check_val("rst_busy_trip", {busy, wdog_trip}, 0);
      rst = 1'b1;
      cyc(1);
      check_val("ready_after_release", cmd_ready, 1);

      // Ramp up: L fwd/11, R fwd/01
      send(1'b0, 2'd3, 1'b0, 2'd1);
      check_val("up_busy", busy, 1);
      cyc(3);  check_val("up_l_p3", speed_l, 0);
      cyc(1);  check_val("up_l_p4", speed_l, 1); check_val("up_r_p4", speed_r, 1);
      cyc(4);  check_val("up_l_p8", speed_l, 2); check_val("up_r_p8", speed_r, 1);
      cyc(4);  check_val("up_l_p12", speed_l, 3);
      cyc(1);  check_val("up_idle", busy, 0);

      // Accept equal to current state stays idle
      send(1'b0, 2'd3, 1'b0, 2'd1);
      check_val("same_cmd_idle", busy, 0);

      // Reversal of L to rev/10
      send(1'b1, 2'd2, 1'b0, 2'd1);
      cyc(4);  check_val("rev_l_p4", speed_l, 2);
      cyc(4);  check_val("rev_l_p8", speed_l, 1);
      cyc(4);  check_val("rev_l_p12", speed_l, 0); check_val("rev_ready_p12", cmd_ready, 1);
      cyc(1);  check_val("rev_dead_ready", cmd_ready, 0);
      cyc(5);  check_val("rev_dead_last_ready", cmd_ready, 0); check_val("rev_dead_dir", dir_l, 0);
      cyc(1);  check_val("rev_exit_ready", cmd_ready, 1); check_val("rev_exit_dir", dir_l, 1);
               check_val("rev_exit_spd", speed_l, 0); check_val("rev_r_dir", dir_r, 0);
      cyc(4);  check_val("rev_up_1", speed_l, 1);
      cyc(4);  check_val("rev_up_2", speed_l, 2);
      cyc(1);  check_val("rev_idle", busy, 0);

      // Retarget R mid-ramp without disturbing tick phase
      send(1'b1, 2'd2, 1'b0, 2'd3);
      cyc(1);
      send(1'b1, 2'd2, 1'b0, 2'd2);
      cyc(1);  check_val("rt_r_p3", speed_r, 1);
      cyc(1);  check_val("rt_r_p4", speed_r, 2);
      cyc(1);  check_val("rt_idle", busy, 0);
      cyc(3);  check_val("rt_r_hold", speed_r, 2);

      // Watchdog expiry
      send(1'b1, 2'd3, 1'b0, 2'd3);
      cyc(4);  check_val("wd_full", {speed_l, speed_r}, 4'hF);
      cyc(94); check_val("wd_p98_trip", wdog_trip, 0); check_val("wd_p98_busy", busy, 0);
      cyc(1);  check_val("wd_p99_trip", wdog_trip, 1); check_val("wd_p99_busy", busy, 1);
      cyc(4);  check_val("wd_down1", {speed_l, speed_r}, 4'hA);
      cyc(8);  check_val("wd_stop", {speed_l, speed_r}, 4'h0);
      cyc(1);  check_val("wd_idle", busy, 0); check_val("wd_dirs", {dir_l, dir_r}, 2'b10);
               check_val("wd_sticky", wdog_trip, 1);

      // Accept clears trip; accept on the expiry cycle wins
      send(1'b1, 2'd1, 1'b0, 2'd1);
      check_val("clr_trip", wdog_trip, 0);
      cyc(4);  check_val("clr_spd", {speed_l, speed_r}, 4'h5);
      cyc(94); check_val("sim_p98_trip", wdog_trip, 0);
      send(1'b1, 2'd2, 1'b0, 2'd2);
      check_val("sim_trip", wdog_trip, 0); check_val("sim_busy", busy, 1);
      cyc(4);  check_val("sim_spd", {speed_l, speed_r}, 4'hA); check_val("sim_trip_late", wdog_trip, 0);
      cyc(2);

      // Async reset in the middle of a dead time
      send(1'b0, 2'd2, 1'b0, 2'd2);
      cyc(8);  check_val("ar_l_zero", speed_l, 0);
      cyc(3);  check_val("ar_in_dead", cmd_ready, 0); check_val("ar_r_pre", speed_r, 2);
      #2 rst = 1'b0;
      #1;
      check_val("ar_spd", {speed_l, speed_r}, 0);
      check_val("ar_dirs", {dir_l, dir_r}, 0);
      check_val("ar_ready", cmd_ready, 0);
      check_val("ar_busy", busy, 0);
      cyc(3);  check_val("ar_hold_ready", cmd_ready, 0);
      rst = 1'b1;
      cyc(1);  check_val("ar_release_ready", cmd_ready, 1); check_val("ar_release_busy", busy, 0);

      check_val("dir_only_at_zero", bad_dir, 0);
      check_val("single_code_steps", bad_step, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
